// File: rtl/dvi_to_vga_converter.sv
// Reassembles 24-bit RGB pixels from a 12-bit, two-cycles-per-pixel DVI bus.
// Tracks pixel/line position, measures active resolution and reports lock/framing errors.
module dvi_to_vga_converter #(
  parameter int H_ACTIVE_COUNT = 24,
  parameter int V_ACTIVE_COUNT = 16
) (
  input  logic        iClk_0,
  input  logic        iRst,
  input  logic [11:0] iData,
  input  logic        iHsync,
  input  logic        iVsync,
  input  logic        iDe,
  input  logic        iClearError,
  output logic [7:0]  oDataRed,
  output logic [7:0]  oDataGreen,
  output logic [7:0]  oDataBlue,
  output logic        oPixelValid,
  output logic [11:0] oPixelX,
  output logic [11:0] oPixelY,
  output logic        oFrameStart,
  output logic        oHsync,
  output logic        oVsync,
  output logic [11:0] oMeasuredWidth,
  output logic [11:0] oMeasuredHeight,
  output logic        oLocked,
  output logic        oError
);

  localparam logic [11:0] H_W = 12'(H_ACTIVE_COUNT);
  localparam logic [11:0] V_W = 12'(V_ACTIVE_COUNT);

  typedef enum logic {PH_FIRST = 1'b0, PH_SECOND = 1'b1} phase_e;

  phase_e      phase_q, phase_d;
  logic [11:0] half_a_q, half_a_d;
  logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        frame_start_q, frame_start_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0] width_q, width_d, height_q, height_d;
  logic        locked_q, locked_d, error_q, error_d;
  logic [11:0] px_cnt_q, px_cnt_d, line_idx_q, line_idx_d;
  logic        de_prev_q, de_prev_d, vsync_prev_q, vsync_prev_d;
  logic        de_seen_low_q, de_seen_low_d;
  logic        frame_armed_q, frame_armed_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  good_cnt_q, good_cnt_d;

  logic        de_eff, de_fall, vsync_fall, err_event;
  logic [1:0]  next_cnt;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  always_comb begin
    phase_d       = phase_q;
    half_a_d      = half_a_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    hsync_d       = iHsync;
    vsync_d       = iVsync;
    width_d       = width_q;
    height_d      = height_q;
    locked_d      = locked_q;
    error_d       = error_q;
    px_cnt_d      = px_cnt_q;
    line_idx_d    = line_idx_q;
    frame_armed_d = frame_armed_q;
    good_cnt_d    = good_cnt_q;
    next_cnt      = good_cnt_q;
    err_event     = 1'b0;

    // DE is ignored until it has been seen low once, so a line cut by reset is dropped whole.
    de_eff        = iDe & de_seen_low_q;
    de_seen_low_d = de_seen_low_q | ~iDe;
    de_prev_d     = de_eff;
    vsync_prev_d  = iVsync;
    de_fall       = de_prev_q & ~de_eff;
    vsync_fall    = vsync_prev_q & ~iVsync;

    if (de_eff) begin
      if (phase_q == PH_FIRST) begin
        half_a_d = iData;
        phase_d  = PH_SECOND;
      end else begin
        red_d         = half_a_q[11:4];
        green_d       = {half_a_q[3:0], iData[11:8]};
        blue_d        = iData[7:0];
        pix_valid_d   = 1'b1;
        pix_x_d       = px_cnt_q;
        pix_y_d       = line_idx_q;
        frame_start_d = frame_armed_q;
        frame_armed_d = 1'b0;
        px_cnt_d      = sat_inc(px_cnt_q);
        phase_d       = PH_FIRST;
      end
    end else begin
      if (phase_q == PH_SECOND) begin
        err_event = 1'b1;
        half_a_d  = 12'd0;
      end
      phase_d = PH_FIRST;
    end

    if (de_fall) begin
      width_d    = px_cnt_q;
      px_cnt_d   = 12'd0;
      line_idx_d = sat_inc(line_idx_q);
      if (px_cnt_q != H_W) err_event = 1'b1;
    end

    if (vsync_fall) begin
      height_d      = line_idx_q;
      line_idx_d    = 12'd0;
      frame_armed_d = 1'b1;
      if (line_idx_q == V_W && !frame_err_q && !err_event) begin
        next_cnt   = (good_cnt_q == 2'd2) ? 2'd2 : good_cnt_q + 2'd1;
        good_cnt_d = next_cnt;
        if (next_cnt == 2'd2) locked_d = 1'b1;
      end else begin
        good_cnt_d = 2'd0;
        locked_d   = 1'b0;
      end
    end

    frame_err_d = (vsync_fall ? 1'b0 : frame_err_q) | err_event;

    // A new error outranks a simultaneous clear request.
    if (err_event) begin
      error_d  = 1'b1;
      locked_d = 1'b0;
    end else if (iClearError) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge iClk_0) begin
    if (iRst) begin
      phase_q       <= PH_FIRST;
      half_a_q      <= 12'd0;
      red_q         <= 8'd0;
      green_q       <= 8'd0;
      blue_q        <= 8'd0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 12'd0;
      pix_y_q       <= 12'd0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      width_q       <= 12'd0;
      height_q      <= 12'd0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      px_cnt_q      <= 12'd0;
      line_idx_q    <= 12'd0;
      de_prev_q     <= 1'b0;
      vsync_prev_q  <= 1'b1;
      de_seen_low_q <= 1'b0;
      frame_armed_q <= 1'b0;
      frame_err_q   <= 1'b0;
      good_cnt_q    <= 2'd0;
    end else begin
      phase_q       <= phase_d;
      half_a_q      <= half_a_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      width_q       <= width_d;
      height_q      <= height_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
      px_cnt_q      <= px_cnt_d;
      line_idx_q    <= line_idx_d;
      de_prev_q     <= de_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      de_seen_low_q <= de_seen_low_d;
      frame_armed_q <= frame_armed_d;
      frame_err_q   <= frame_err_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign oDataRed        = red_q;
  assign oDataGreen      = green_q;
  assign oDataBlue       = blue_q;
  assign oPixelValid     = pix_valid_q;
  assign oPixelX         = pix_x_q;
  assign oPixelY         = pix_y_q;
  assign oFrameStart     = frame_start_q;
  assign oHsync          = hsync_q;
  assign oVsync          = vsync_q;
  assign oMeasuredWidth  = width_q;
  assign oMeasuredHeight = height_q;
  assign oLocked         = locked_q;
  assign oError          = error_q;

endmodule

// File: tb/tb_dvi_to_vga_converter.sv
// Directed bench for dvi_to_vga_converter: table of line scenarios plus frame,
// lock-recovery and mid-line-reset sequences, with an expected-pixel queue.
module tb_dvi_to_vga_converter;

  logic        clk = 1'b0;
  logic        iRst;
  logic [11:0] iData;
  logic        iHsync, iVsync, iDe, iClearError;
  logic [7:0]  oDataRed, oDataGreen, oDataBlue;
  logic        oPixelValid;
  logic [11:0] oPixelX, oPixelY;
  logic        oFrameStart, oHsync, oVsync;
  logic [11:0] oMeasuredWidth, oMeasuredHeight;
  logic        oLocked, oError;

  dvi_to_vga_converter #(.H_ACTIVE_COUNT(24), .V_ACTIVE_COUNT(16)) dut (
    .iClk_0(clk), .iRst(iRst), .iData(iData), .iHsync(iHsync), .iVsync(iVsync),
    .iDe(iDe), .iClearError(iClearError),
    .oDataRed(oDataRed), .oDataGreen(oDataGreen), .oDataBlue(oDataBlue),
    .oPixelValid(oPixelValid), .oPixelX(oPixelX), .oPixelY(oPixelY),
    .oFrameStart(oFrameStart), .oHsync(oHsync), .oVsync(oVsync),
    .oMeasuredWidth(oMeasuredWidth), .oMeasuredHeight(oMeasuredHeight),
    .oLocked(oLocked), .oError(oError)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {frame_start, y, x, r, g, b}
  logic [48:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;
  int          fs_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [11:0] exp_y = 12'd0;
  logic        exp_armed = 1'b0;

  typedef struct {
    int         de_len;
    logic [7:0] green;
    logic       clear_first;
    int         exp_strobes;
    logic [11:0] exp_width;
    logic       exp_error;
  } line_vec_t;

  line_vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [48:0] e;
    @(posedge clk);
    #1;
    if (oPixelValid) begin
      strobe_cnt++;
      if (oFrameStart) fs_cnt++;
      check("no_back_to_back", {63'd0, prev_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d expected no strobe", oPixelX, oPixelY);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {15'd0, oFrameStart, oPixelY, oPixelX, oDataRed, oDataGreen, oDataBlue},
              {15'd0, e});
      end
    end
    prev_valid = oPixelValid;
  endtask

  // driver tasks
  task automatic do_reset();
    iRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iDe    = 1'($urandom_range(0, 1));
      iData  = 12'($urandom_range(0, 4095));
      iHsync = 1'($urandom_range(0, 1));
      iVsync = 1'($urandom_range(0, 1));
      iClearError = 1'($urandom_range(0, 1));
      step();
    end
    check("rst_rgb", {40'd0, oDataRed, oDataGreen, oDataBlue}, 64'd0);
    check("rst_valid_fs", {62'd0, oPixelValid, oFrameStart}, 64'd0);
    check("rst_xy", {40'd0, oPixelX, oPixelY}, 64'd0);
    check("rst_syncs", {62'd0, oHsync, oVsync}, 64'd3);
    check("rst_measured", {40'd0, oMeasuredWidth, oMeasuredHeight}, 64'd0);
    check("rst_lock_err", {62'd0, oLocked, oError}, 64'd0);
    iRst = 1'b0; iDe = 1'b0; iData = 12'd0; iHsync = 1'b1; iVsync = 1'b1; iClearError = 1'b0;
    step();
    step();
    exp_q.delete();
    exp_y = 12'd0;
    exp_armed = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [7:0] g);
    logic [7:0]  r, b;
    logic [11:0] k;
    for (int c = 0; c < n; c++) begin
      k = 12'(c / 2);
      r = k[7:0];
      b = 8'hFF - k[7:0];
      iDe = 1'b1;
      if (c % 2 == 0) begin
        iData = {r, g[7:4]};
      end else begin
        iData = {g[3:0], b};
        exp_q.push_back({exp_armed, exp_y, k, r, g, b});
        exp_armed = 1'b0;
      end
      step();
    end
    iDe = 1'b0;
    iData = 12'($urandom_range(0, 4095));
    step();
    exp_y = exp_y + 12'd1;
    iHsync = 1'b0;
    step();
    check("hsync_low", {63'd0, oHsync}, 64'd0);
    step();
    iHsync = 1'b1;
    step();
    check("hsync_high", {63'd0, oHsync}, 64'd1);
    step();
  endtask

  task automatic vsync_pulse();
    iVsync = 1'b0;
    step();
    check("vsync_low", {63'd0, oVsync}, 64'd0);
    step();
    step();
    iVsync = 1'b1;
    step();
    check("vsync_high", {63'd0, oVsync}, 64'd1);
    step();
    exp_y = 12'd0;
    exp_armed = 1'b1;
  endtask

  task automatic clear_pulse();
    iClearError = 1'b1;
    step();
    iClearError = 1'b0;
    check("clear_error", {63'd0, oError}, 64'd0);
  endtask

  task automatic send_frame(input logic [7:0] g, input logic exp_locked, input int exp_fs);
    int fs0;
    fs0 = fs_cnt;
    for (int l = 0; l < 16; l++) send_line(48, g + 8'(l));
    vsync_pulse();
    check("frame_height", {52'd0, oMeasuredHeight}, 64'd16);
    check("frame_locked", {63'd0, oLocked}, {63'd0, exp_locked});
    check("frame_error", {63'd0, oError}, 64'd0);
    check("frame_start_count", 64'(fs_cnt - fs0), 64'(exp_fs));
    check("frame_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s0;
    vecs[0] = '{48, 8'hA5, 1'b0, 24, 12'd24, 1'b0};
    vecs[1] = '{48, 8'h3C, 1'b0, 24, 12'd24, 1'b0};
    vecs[2] = '{49, 8'h5A, 1'b0, 24, 12'd24, 1'b1};
    vecs[3] = '{48, 8'hC3, 1'b1, 24, 12'd24, 1'b0};
    vecs[4] = '{40, 8'h0F, 1'b0, 20, 12'd20, 1'b1};
    vecs[5] = '{48, 8'hF0, 1'b1, 24, 12'd24, 1'b0};

    iRst = 1'b1; iData = 12'd0; iHsync = 1'b1; iVsync = 1'b1; iDe = 1'b0; iClearError = 1'b0;
    do_reset();

    // line scenarios
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clear_first) clear_pulse();
      s0 = strobe_cnt;
      send_line(vecs[v].de_len, vecs[v].green);
      check("line_strobes", 64'(strobe_cnt - s0), 64'(vecs[v].exp_strobes));
      check("line_width", {52'd0, oMeasuredWidth}, {52'd0, vecs[v].exp_width});
      check("line_error", {63'd0, oError}, {63'd0, vecs[v].exp_error});
      check("line_queue_empty", 64'(exp_q.size()), 64'd0);
    end
    check("table_locked", {63'd0, oLocked}, 64'd0);

    // partial frame of 6 lines is a bad frame, then three clean frames
    vsync_pulse();
    check("short_height", {52'd0, oMeasuredHeight}, 64'd6);
    check("short_locked", {63'd0, oLocked}, 64'd0);
    send_frame(8'h10, 1'b0, 1);
    send_frame(8'h20, 1'b1, 1);
    send_frame(8'h30, 1'b1, 1);

    // odd DE breaks lock; recovery needs two clean frames
    send_line(49, 8'h66);
    check("odd_error", {63'd0, oError}, 64'd1);
    check("odd_unlocked", {63'd0, oLocked}, 64'd0);
    send_line(48, 8'h99);
    check("after_odd_width", {52'd0, oMeasuredWidth}, 64'd24);
    clear_pulse();
    vsync_pulse();
    check("bad_frame_height", {52'd0, oMeasuredHeight}, 64'd2);
    check("bad_frame_locked", {63'd0, oLocked}, 64'd0);
    send_frame(8'h40, 1'b0, 1);
    send_frame(8'h50, 1'b1, 1);

    // reset in the middle of a line
    for (int c = 0; c < 48; c++) begin
      logic [11:0] k;
      k = 12'(c / 2);
      iDe = 1'b1;
      iRst = (c == 15);
      if (c % 2 == 0) iData = {k[7:0], 4'hE};
      else begin
        iData = {4'h1, 8'hFF - k[7:0]};
        if (c < 15) begin
          exp_q.push_back({exp_armed, exp_y, k, k[7:0], 8'hE1, 8'hFF - k[7:0]});
          exp_armed = 1'b0;
        end
      end
      step();
      if (c == 15) begin
        check("midrst_locked", {63'd0, oLocked}, 64'd0);
        check("midrst_measured", {40'd0, oMeasuredWidth, oMeasuredHeight}, 64'd0);
        check("midrst_valid", {63'd0, oPixelValid}, 64'd0);
        s0 = strobe_cnt;
      end
    end
    iRst = 1'b0;
    iDe = 1'b0;
    step();
    step();
    check("midrst_no_strobes", 64'(strobe_cnt - s0), 64'd0);
    exp_y = 12'd0;
    exp_armed = 1'b0;
    s0 = strobe_cnt;
    send_line(48, 8'h77);
    check("post_rst_strobes", 64'(strobe_cnt - s0), 64'd24);
    check("post_rst_width", {52'd0, oMeasuredWidth}, 64'd24);
    check("post_rst_error", {63'd0, oError}, 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
